ethernet_frame_generator: RTL and testbench

// - Stimulus source for MII/BASE-R verification. Emits one byte per clock of a minimum-size Ethernet frame

---
 rtl/ethernet_frame_generator.sv | 158 +++++++++++++++
 tb/tb_ethernet_frame_generator.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/ethernet_frame_generator.sv
// Minimum-size Ethernet frame source for MII/BASE-R benches: one byte per clock,
// wrapped in IDLE/START/TERMINATE control codes, with optional malformed-frame scenarios.
module ethernet_frame_generator #(
  parameter int          IDLE_CYCLES     = 12,
  parameter int          PREAMBLE_CYCLES = 7,
  parameter int          SFD_CYCLES      = 1,
  parameter int          DST_ADDR_CYCLES = 6,
  parameter int          SRC_ADDR_CYCLES = 6,
  parameter int          LEN_TYP_CYCLES  = 2,
  parameter int          DATA_CYCLES     = 46,
  parameter int          FCS_CYCLES      = 4,
  parameter logic [7:0]  IDLE_CODE       = 8'h07,
  parameter logic [7:0]  START_CODE      = 8'hFB,
  parameter logic [7:0]  TERMINATE_CODE  = 8'hFD,
  parameter logic [7:0]  PREAMBLE_CODE   = 8'h55,
  parameter logic [7:0]  SFD_CODE        = 8'hD5,
  parameter logic [7:0]  DST_ADDR_CODE   = 8'h01,
  parameter logic [7:0]  SRC_ADDR_CODE   = 8'h02,
  parameter logic [7:0]  LEN_TYP_CODE    = 8'h03,
  parameter logic [7:0]  FCS_CODE        = 8'h04
) (
  input  logic       clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_interrupt,
  output logic [7:0] o_tx_data,
  output logic [7:0] o_tx_ctrl
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_PRE, S_SFD, S_DST, S_SRC, S_LEN, S_DATA, S_FCS, S_TERM
  } state_t;

  localparam logic [7:0] MODE_TRUNC = 8'd1;
  localparam logic [7:0] MODE_NOFCS = 8'd2;
  localparam logic [7:0] MODE_ERR   = 8'd3;
  localparam logic [7:0] CTRL_ON    = 8'hFF;
  localparam logic [7:0] CTRL_OFF   = 8'h00;
  localparam logic [7:0] ERR_CODE   = 8'hFE;
  localparam logic [7:0] DATA_LAST  = 8'(DATA_CYCLES - 1);
  localparam logic [7:0] DATA_HALF  = 8'(DATA_CYCLES / 2);
  // cnt value while emitting the last payload byte of a truncated frame
  localparam logic [7:0] TRUNC_CNT  = 8'(DATA_CYCLES - DATA_CYCLES / 2);

  state_t     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] ipg_q, ipg_d;
  logic [7:0] mode_q, mode_d;
  logic [7:0] data_q, data_d;
  logic [7:0] ctrl_q, ctrl_d;
  logic [7:0] idx;

  assign idx = DATA_LAST - cnt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ipg_d   = ipg_q;
    mode_d  = mode_q;
    if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
    case (state_q)
      S_IDLE: begin
        if (ipg_q != 8'd0) begin
          ipg_d = ipg_q - 8'd1;
        end else if (i_start) begin
          state_d = S_START;
          mode_d  = i_interrupt;
        end
      end
      S_START: begin
        state_d = S_PRE;
        cnt_d   = 8'(PREAMBLE_CYCLES - 1);
      end
      S_PRE: if (cnt_q == 8'd0) begin
        state_d = S_SFD;
        cnt_d   = 8'(SFD_CYCLES - 1);
      end
      S_SFD: if (cnt_q == 8'd0) begin
        state_d = S_DST;
        cnt_d   = 8'(DST_ADDR_CYCLES - 1);
      end
      S_DST: if (cnt_q == 8'd0) begin
        state_d = S_SRC;
        cnt_d   = 8'(SRC_ADDR_CYCLES - 1);
      end
      S_SRC: if (cnt_q == 8'd0) begin
        state_d = S_LEN;
        cnt_d   = 8'(LEN_TYP_CYCLES - 1);
      end
      S_LEN: if (cnt_q == 8'd0) begin
        state_d = S_DATA;
        cnt_d   = DATA_LAST;
      end
      S_DATA: begin
        if (mode_q == MODE_TRUNC && cnt_q == TRUNC_CNT) begin
          state_d = S_TERM;
        end else if (cnt_q == 8'd0) begin
          state_d = (mode_q == MODE_NOFCS) ? S_TERM : S_FCS;
          cnt_d   = 8'(FCS_CYCLES - 1);
        end
      end
      S_FCS: if (cnt_q == 8'd0) state_d = S_TERM;
      S_TERM: begin
        state_d = S_IDLE;
        // the TERM->IDLE cycle counts toward the gap, hence the -1
        ipg_d   = 8'(IDLE_CYCLES - 1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output byte is a function of the current state, registered one cycle later.
  always_comb begin
    data_d = IDLE_CODE;
    ctrl_d = CTRL_ON;
    case (state_q)
      S_START: data_d = START_CODE;
      S_PRE:   begin data_d = PREAMBLE_CODE; ctrl_d = CTRL_OFF; end
      S_SFD:   begin data_d = SFD_CODE;      ctrl_d = CTRL_OFF; end
      S_DST:   begin data_d = DST_ADDR_CODE; ctrl_d = CTRL_OFF; end
      S_SRC:   begin data_d = SRC_ADDR_CODE; ctrl_d = CTRL_OFF; end
      S_LEN:   begin data_d = LEN_TYP_CODE;  ctrl_d = CTRL_OFF; end
      S_DATA: begin
        data_d = idx;
        ctrl_d = CTRL_OFF;
        if (mode_q == MODE_ERR && idx == DATA_HALF) begin
          data_d = ERR_CODE;
          ctrl_d = CTRL_ON;
        end
      end
      S_FCS:   begin data_d = FCS_CODE;      ctrl_d = CTRL_OFF; end
      S_TERM:  data_d = TERMINATE_CODE;
      default: data_d = IDLE_CODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      ipg_q   <= 8'd0;
      mode_q  <= 8'd0;
      data_q  <= IDLE_CODE;
      ctrl_q  <= CTRL_ON;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ipg_q   <= ipg_d;
      mode_q  <= mode_d;
      data_q  <= data_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign o_tx_data = data_q;
  assign o_tx_ctrl = ctrl_q;

endmodule

// File: tb/tb_ethernet_frame_generator.sv
// Directed bench for ethernet_frame_generator: frame contents, latency, IPG,
// ignored starts, scenario modes and mid-frame reset.
module tb_ethernet_frame_generator;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_start = 1'b0;
  logic [7:0] i_interrupt = 8'd0;
  logic [7:0] o_tx_data;
  logic [7:0] o_tx_ctrl;

  int n_chk = 0;
  int n_err = 0;
  int frame_cnt = 0;

  logic [7:0] exp_d [0:79];
  logic [7:0] exp_c [0:79];
  int         exp_len;

  ethernet_frame_generator dut (
    .clk         (clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_interrupt (i_interrupt),
    .o_tx_data   (o_tx_data),
    .o_tx_ctrl   (o_tx_ctrl)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (o_tx_data == 8'hFB && o_tx_ctrl == 8'hFF) frame_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add(input logic [7:0] d, input logic [7:0] c, input int n);
    for (int i = 0; i < n; i++) begin
      exp_d[exp_len] = d;
      exp_c[exp_len] = c;
      exp_len++;
    end
  endtask

  // Expected frame, written straight from the byte map.
  task automatic build(input int mode);
    exp_len = 0;
    add(8'hFB, 8'hFF, 1);
    add(8'h55, 8'h00, 7);
    add(8'hD5, 8'h00, 1);
    add(8'h01, 8'h00, 6);
    add(8'h02, 8'h00, 6);
    add(8'h03, 8'h00, 2);
    for (int i = 0; i < ((mode == 1) ? 23 : 46); i++) begin
      if (mode == 3 && i == 23) add(8'hFE, 8'hFF, 1);
      else                      add(8'(i), 8'h00, 1);
    end
    if (mode == 0 || mode == 3) add(8'h04, 8'h00, 4);
    add(8'hFD, 8'hFF, 1);
  endtask

  // Entered at the negedge where START is visible; leaves at the first byte after FD.
  task automatic run_frame(input int mode, input int pulse_at);
    build(mode);
    for (int k = 0; k < exp_len; k++) begin
      chk($sformatf("m%0d_b%0d", mode, k), {16'h0, o_tx_data, o_tx_ctrl},
          {16'h0, exp_d[k], exp_c[k]});
      if (pulse_at >= 0 && k == pulse_at)     i_start = 1'b1;
      if (pulse_at >= 0 && k == pulse_at + 1) i_start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic idle_watch(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s_%0d", tag, k), {16'h0, o_tx_data, o_tx_ctrl}, 32'h07FF);
      @(negedge clk);
    end
  endtask

  task automatic count_gap(output int n);
    n = 0;
    while (!(o_tx_data == 8'hFB && o_tx_ctrl == 8'hFF) && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  // Pulse i_start for one sampling edge; returns at the negedge right after acceptance.
  task automatic pulse_start(input logic [7:0] intr);
    i_interrupt = intr;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  initial begin
    int gap;
    repeat (20) @(negedge clk);
    chk("reset_out", {16'h0, o_tx_data, o_tx_ctrl}, 32'h07FF);
    i_rst = 1'b0;
    @(negedge clk);

    // normal frame, latency of one cycle after acceptance
    pulse_start(8'd0);
    chk("lat0", {16'h0, o_tx_data, o_tx_ctrl}, 32'h07FF);
    @(negedge clk);
    run_frame(0, -1);
    idle_watch("idle_after0", 20);

    // i_start held high: back-to-back frames with exactly 12 idles
    i_start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    run_frame(0, -1);
    count_gap(gap);
    chk("b2b_gap", 32'(gap), 32'd12);
    i_start = 1'b0;
    run_frame(0, -1);
    idle_watch("idle_after_b2b", 20);

    // starts mid-frame and inside the gap are dropped
    pulse_start(8'd0);
    @(negedge clk);
    run_frame(0, 30);
    repeat (4) @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    idle_watch("ignored", 40);
    chk("frames_so_far", 32'(frame_cnt), 32'd4);

    // scenarios; mode 3 also checks that i_interrupt is latched at start
    pulse_start(8'd1);
    i_interrupt = 8'd0;
    @(negedge clk);
    run_frame(1, -1);
    idle_watch("idle_m1", 15);
    pulse_start(8'd2);
    @(negedge clk);
    run_frame(2, -1);
    idle_watch("idle_m2", 15);
    pulse_start(8'd3);
    i_interrupt = 8'd0;
    @(negedge clk);
    run_frame(3, -1);
    idle_watch("idle_m3", 15);
    pulse_start(8'd9);
    i_interrupt = 8'd0;
    @(negedge clk);
    run_frame(0, -1);
    idle_watch("idle_m9", 15);

    // reset mid-DATA, then an immediate new start
    pulse_start(8'd0);
    repeat (31) @(negedge clk);
    chk("in_data", 32'({o_tx_data, o_tx_ctrl}), {16'h0, 8'd7, 8'h00});
    i_rst = 1'b1;
    @(negedge clk);
    chk("rst_mid", {16'h0, o_tx_data, o_tx_ctrl}, 32'h07FF);
    i_rst = 1'b0;
    pulse_start(8'd0);
    chk("rst_lat", {16'h0, o_tx_data, o_tx_ctrl}, 32'h07FF);
    @(negedge clk);
    run_frame(0, -1);
    idle_watch("idle_end", 15);
    chk("frames_total", 32'(frame_cnt), 32'd10);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
